// File: rtl/matrix_pkg.sv
// Shared types and constants for the UART matrix-multiplier sequencer.
package matrix_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      START,
      WAIT_MULT,
      READ,
      SEND,
      WAIT_TX
   } state_t;

   // Default frame start byte
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Index of the last element of an n x n matrix; callers size it to their address width
   function automatic int unsigned last_idx(input int unsigned n);
      return n * n - 1;
   endfunction

endpackage

// File: rtl/matrix_seq_ctrl.sv
// Sequencer: frames UART bytes into the A/B memories, starts the multiplier,
// then streams every result word out through the UART transmitter, MSB byte first.
module matrix_seq_ctrl
   import matrix_pkg::*;
#(
   parameter int unsigned N    = 3,
   parameter int unsigned DW   = 8,
   parameter int unsigned RW   = 16,
   parameter int unsigned AW   = 6,
   parameter logic [7:0]  SYNC = SYNC_BYTE
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   input  logic          tx_busy,
   output logic [7:0]    tx_data,
   output logic          tx_start,
   output logic [AW-1:0] a_addr,
   output logic [AW-1:0] b_addr,
   output logic          a_we,
   output logic          b_we,
   output logic [DW-1:0] mem_wdata,
   output logic          mult_start,
   input  logic          mult_done,
   output logic [AW-1:0] res_addr,
   input  logic [RW-1:0] res_data,
   output logic          busy,
   output logic          frame_err
);

   localparam int unsigned   NB    = RW / 8;
   localparam int unsigned   BW    = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [AW-1:0] LAST  = AW'(last_idx(N));
   localparam logic [BW-1:0] BLAST = BW'(NB - 1);

   state_t        r_state;
   logic [AW-1:0] r_idx;
   logic [AW-1:0] r_ridx;
   logic [BW-1:0] r_bcnt;
   logic [RW-1:0] r_shreg;
   logic          r_rd_phase;
   logic          r_grace;
   logic [7:0]    r_tx_data;
   logic          r_tx_start;
   logic [AW-1:0] r_a_addr;
   logic [AW-1:0] r_b_addr;
   logic          r_a_we;
   logic          r_b_we;
   logic [DW-1:0] r_wdata;
   logic          r_mult_start;
   logic [AW-1:0] r_res_addr;
   logic          r_busy;
   logic          r_frame_err;

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_ridx       <= '0;
         r_bcnt       <= '0;
         r_shreg      <= '0;
         r_rd_phase   <= 1'b0;
         r_grace      <= 1'b0;
         r_tx_data    <= '0;
         r_tx_start   <= 1'b0;
         r_a_addr     <= '0;
         r_b_addr     <= '0;
         r_a_we       <= 1'b0;
         r_b_we       <= 1'b0;
         r_wdata      <= '0;
         r_mult_start <= 1'b0;
         r_res_addr   <= '0;
         r_busy       <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_a_we       <= 1'b0;
         r_b_we       <= 1'b0;
         r_tx_start   <= 1'b0;
         r_mult_start <= 1'b0;
         r_frame_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (rx_valid) begin
                  if (rx_data == SYNC) begin
                     r_state <= LOAD_A;
                     r_idx   <= '0;
                     r_busy  <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end
            end
            LOAD_A: begin
               if (rx_valid) begin
                  r_a_we   <= 1'b1;
                  r_a_addr <= r_idx;
                  r_wdata  <= DW'(rx_data);
                  if (r_idx == LAST) begin
                     r_idx   <= '0;
                     r_state <= LOAD_B;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            LOAD_B: begin
               if (rx_valid) begin
                  r_b_we   <= 1'b1;
                  r_b_addr <= r_idx;
                  r_wdata  <= DW'(rx_data);
                  if (r_idx == LAST) begin
                     r_idx   <= '0;
                     r_state <= START;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            START: begin
               r_mult_start <= 1'b1;
               r_state      <= WAIT_MULT;
            end
            WAIT_MULT: begin
               // r_mult_start is still high in the first WAIT_MULT cycle, masking a coincident done
               if (mult_done && !r_mult_start) begin
                  r_ridx     <= '0;
                  r_res_addr <= '0;
                  r_rd_phase <= 1'b0;
                  r_state    <= READ;
               end
            end
            READ: begin
               // phase 0: address presented to memory; phase 1: read data valid
               if (!r_rd_phase) begin
                  r_rd_phase <= 1'b1;
               end else begin
                  r_rd_phase <= 1'b0;
                  r_shreg    <= res_data;
                  r_bcnt     <= BLAST;
                  r_state    <= SEND;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  r_tx_data  <= r_shreg[RW-1 -: 8];
                  r_tx_start <= 1'b1;
                  r_grace    <= 1'b1;
                  r_state    <= WAIT_TX;
               end
            end
            WAIT_TX: begin
               if (r_grace) begin
                  r_grace <= 1'b0;
               end else if (!tx_busy) begin
                  if (r_bcnt != '0) begin
                     r_shreg <= r_shreg << 8;
                     r_bcnt  <= r_bcnt - 1'b1;
                     r_state <= SEND;
                  end else if (r_ridx < LAST) begin
                     r_ridx     <= r_ridx + 1'b1;
                     r_res_addr <= r_ridx + 1'b1;
                     r_state    <= READ;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data    = r_tx_data;
   assign tx_start   = r_tx_start;
   assign a_addr     = r_a_addr;
   assign b_addr     = r_b_addr;
   assign a_we       = r_a_we;
   assign b_we       = r_b_we;
   assign mem_wdata  = r_wdata;
   assign mult_start = r_mult_start;
   assign res_addr   = r_res_addr;
   assign busy       = r_busy;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Scoreboard bench for matrix_seq_ctrl: randomized frames, result memory and
// transmitter models, expected writes/bytes queued at stimulus time.
module tb_matrix_seq_ctrl;

   localparam int unsigned N  = 3;
   localparam int unsigned DW = 8;
   localparam int unsigned RW = 16;
   localparam int unsigned AW = 6;
   localparam int NN = N * N;
   localparam int NB = RW / 8;

   logic          clk;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          tx_busy;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic [AW-1:0] a_addr;
   logic [AW-1:0] b_addr;
   logic          a_we;
   logic          b_we;
   logic [DW-1:0] mem_wdata;
   logic          mult_start;
   logic          mult_done;
   logic [AW-1:0] res_addr;
   logic [RW-1:0] res_data;
   logic          busy;
   logic          frame_err;

   matrix_seq_ctrl #(.N(N), .DW(DW), .RW(RW), .AW(AW), .SYNC(8'hA5)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
      .a_addr(a_addr), .b_addr(b_addr), .a_we(a_we), .b_we(b_we),
      .mem_wdata(mem_wdata), .mult_start(mult_start), .mult_done(mult_done),
      .res_addr(res_addr), .res_data(res_data), .busy(busy), .frame_err(frame_err)
   );

   typedef struct packed {
      logic          is_b;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   int total = 0;
   int bad   = 0;
   wr_t wq[$];
   int  txq[$];
   int  fe_seen = 0;
   int  ms_seen = 0;
   int  tx_seen = 0;
   int  bp_cycles = 0;
   logic [RW-1:0] res_mem [0:(1<<AW)-1];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Result memory: synchronous read, one cycle latency
   initial begin
      logic [AW-1:0] addr_q;
      res_data = '0;
      forever begin
         @(negedge clk);
         addr_q = res_addr;
         @(posedge clk);
         #1 res_data = res_mem[addr_q];
      end
   end

   // UART transmitter model: busy for a programmable time after each tx_start
   initial begin
      int busy_left;
      int n;
      tx_busy   = 1'b0;
      busy_left = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            busy_left = 0;
            tx_busy   = 1'b0;
         end else if (tx_start) begin
            chk("tx_start_while_busy", 32'(tx_busy), 32'(0));
            n = (bp_cycles < 0) ? int'($urandom_range(0, 5)) : bp_cycles;
            busy_left = n;
            tx_busy   = (n > 0);
         end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
         end
      end
   end

   // Monitor: pops and compares whenever the DUT presents a write or a byte
   initial begin
      wr_t e;
      int  eb;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (a_we || b_we) begin
               chk("we_exclusive", 32'(a_we && b_we), 32'(0));
               if (wq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_write: actual a_we=%0d b_we=%0d required=none", a_we, b_we);
               end else begin
                  e = wq.pop_front();
                  chk("wr_select_b", 32'(b_we), 32'(e.is_b));
                  chk("wr_addr", 32'(e.is_b ? b_addr : a_addr), 32'(e.addr));
                  chk("wr_data", 32'(mem_wdata), 32'(e.data));
               end
            end
            if (frame_err)  fe_seen++;
            if (mult_start) ms_seen++;
            if (tx_start) begin
               tx_seen++;
               if (txq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_tx: actual=%0h required=none", tx_data);
               end else begin
                  eb = txq.pop_front();
                  chk("tx_byte", 32'(tx_data), 32'(eb));
               end
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_tx_data"},    32'(tx_data),    32'(0));
      chk({tag, "_tx_start"},   32'(tx_start),   32'(0));
      chk({tag, "_a_addr"},     32'(a_addr),     32'(0));
      chk({tag, "_b_addr"},     32'(b_addr),     32'(0));
      chk({tag, "_a_we"},       32'(a_we),       32'(0));
      chk({tag, "_b_we"},       32'(b_we),       32'(0));
      chk({tag, "_mem_wdata"},  32'(mem_wdata),  32'(0));
      chk({tag, "_mult_start"}, 32'(mult_start), 32'(0));
      chk({tag, "_res_addr"},   32'(res_addr),   32'(0));
      chk({tag, "_busy"},       32'(busy),       32'(0));
      chk({tag, "_frame_err"},  32'(frame_err),  32'(0));
   endtask

   // One byte strobe followed by a gap (negative gap = random 0..3)
   task automatic send_byte(input logic [7:0] b, input int gap);
      int g;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) @(negedge clk);
   endtask

   // Send SYNC plus na A bytes and nb B bytes; A/B expected writes queued row-major
   task automatic load_bytes(input int mode, input int na, input int nb);
      wr_t w;
      logic [7:0] d;
      send_byte(8'hA5, -1);
      for (int i = 0; i < na; i++) begin
         d = (mode == 0) ? 8'(i + 1) : 8'($urandom);
         w.is_b = 1'b0; w.addr = AW'(i); w.data = d;
         wq.push_back(w);
         send_byte(d, (nb == 0 && i == na - 1) ? 0 : -1);
      end
      for (int i = 0; i < nb; i++) begin
         d = (mode == 0) ? 8'(NN - i) : 8'($urandom);
         w.is_b = 1'b1; w.addr = AW'(i); w.data = d;
         wq.push_back(w);
         send_byte(d, (i == nb - 1) ? 0 : -1);
      end
   endtask

   // Fill the result memory and queue the expected byte stream, MSB byte first
   task automatic prep_results(input int mode);
      for (int i = 0; i < NN; i++) begin
         res_mem[i] = (mode == 0) ? RW'(16'h0100 + i) : RW'($urandom);
         for (int k = NB - 1; k >= 0; k--)
            txq.push_back(int'((res_mem[i] >> (8 * k)) & RW'(8'hFF)));
      end
   endtask

   task automatic wait_mult_start(output bit found);
      found = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (mult_start) begin
            found = 1'b1;
            break;
         end
      end
      chk("mult_start_seen", 32'(found), 32'(1));
   endtask

   task automatic pulse_done();
      mult_done = 1'b1;
      @(negedge clk);
      mult_done = 1'b0;
   endtask

   task automatic run_frame(input int mode, input int bp, input bit early, input bit junk);
      int ms0, tx0, fe0;
      bit found;
      ms0 = ms_seen; tx0 = tx_seen; fe0 = fe_seen;
      bp_cycles = bp;
      prep_results(mode);
      load_bytes(mode, NN, NN);
      wait_mult_start(found);
      if (early) begin
         // done coincident with the start pulse must not release WAIT_MULT
         pulse_done();
         repeat (10) @(negedge clk);
         chk("early_done_no_tx", 32'(tx_seen - tx0), 32'(0));
         chk("early_done_busy", 32'(busy), 32'(1));
      end
      if (junk) begin
         send_byte(8'h3C, 0);
         send_byte(8'hA5, 0);
      end
      repeat (20) @(negedge clk);
      pulse_done();
      for (int t = 0; t < 12000 && (busy || txq.size() != 0); t++) @(negedge clk);
      chk("frame_end_busy", 32'(busy), 32'(0));
      chk("tx_count", 32'(tx_seen - tx0), 32'(NN * NB));
      chk("mult_start_count", 32'(ms_seen - ms0), 32'(1));
      chk("frame_err_none", 32'(fe_seen - fe0), 32'(0));
      chk("writes_drained", 32'(wq.size()), 32'(0));
   endtask

   task automatic async_reset(input string tag);
      rst = 1'b0;
      #1;
      check_zero(tag);
      wq.delete();
      txq.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int fe0, tx0;
      bit found;
      rst       = 1'b1;
      rx_data   = '0;
      rx_valid  = 1'b0;
      mult_done = 1'b0;
      for (int i = 0; i < (1 << AW); i++) res_mem[i] = '0;
      #2 rst = 1'b0;

      // Reset held with random inputs
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         rx_data   = 8'($urandom);
         rx_valid  = 1'($urandom);
         mult_done = 1'($urandom);
         #1;
         check_zero("reset");
      end
      @(negedge clk);
      rx_valid  = 1'b0;
      mult_done = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      check_zero("post_reset");

      // Directed frame: A=1..9, B=9..1, results 0x0100+addr
      run_frame(0, -1, 1'b0, 1'b0);

      // Heavy backpressure
      run_frame(1, 200, 1'b0, 1'b0);

      // Framing errors in IDLE, then a frame with bytes dropped during WAIT_MULT
      fe0 = fe_seen;
      send_byte(8'h00, 2);
      send_byte(8'hFF, 2);
      repeat (3) @(negedge clk);
      chk("frame_err_pulses", 32'(fe_seen - fe0), 32'(2));
      chk("frame_err_idle_busy", 32'(busy), 32'(0));
      run_frame(1, -1, 1'b0, 1'b1);

      // Done coincident with the start pulse, transmitter never busy
      run_frame(1, 0, 1'b1, 1'b0);

      // Reset during LOAD_B at idx 4
      bp_cycles = -1;
      load_bytes(1, NN, 4);
      @(negedge clk);
      chk("loadb_writes_done", 32'(wq.size()), 32'(0));
      async_reset("rst_loadb");
      run_frame(1, -1, 1'b0, 1'b0);

      // Reset during WAIT_TX
      bp_cycles = 200;
      tx0 = tx_seen;
      prep_results(1);
      load_bytes(1, NN, NN);
      wait_mult_start(found);
      repeat (20) @(negedge clk);
      pulse_done();
      for (int t = 0; t < 100 && tx_seen == tx0; t++) @(negedge clk);
      chk("first_tx_before_reset", 32'(tx_seen - tx0), 32'(1));
      repeat (5) @(negedge clk);
      chk("wait_tx_busy", 32'(busy), 32'(1));
      async_reset("rst_waittx");
      run_frame(0, -1, 1'b0, 1'b0);

      // Random mix
      for (int f = 0; f < 3; f++)
         run_frame(1, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
